// File: rtl/backlight_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : backlight_mode_ctrl
// Brief    : Key/DIP mode sequencer with vsync-aligned commit and brightness
//            ramp. Optional macro VSYNC_TIMEOUT_EN adds a vsync-loss commit.
// Revision : 1.0 - initial release
// ============================================================================
module backlight_mode_ctrl #(
    parameter int CLK_FREQ_HZ    = 50000000,
    parameter int LONG_PRESS_MS  = 1000,
    parameter int RAMP_STEP_CYC  = 50000,
    parameter int BRIGHT_MIN     = 16,
    parameter int FIXED_BRIGHT   = 255,
    parameter int VS_TIMEOUT_CYC = 5000000
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_vsync,
    input  logic       I_key_rms_n,
    input  logic       I_key_max_n,
    input  logic       I_key_ave_n,
    input  logic       I_key_cor_n,
    input  logic       I_zonal_en,
    input  logic       I_auto_bright,
    input  logic [7:0] I_bright,
    output logic [1:0] O_gray_mode,
    output logic [1:0] O_sub_mode,
    output logic [1:0] O_led_mode,
    output logic [7:0] O_global_bright,
    output logic       O_ramp_busy,
    output logic       O_cfg_update
);

    localparam int c_long_cyc = CLK_FREQ_HZ / 1000 * LONG_PRESS_MS;
    localparam int c_hold_w   = $clog2(c_long_cyc + 1);
    localparam int c_step_w   = $clog2(RAMP_STEP_CYC + 1);

    localparam logic [c_hold_w-1:0] c_long_v    = c_hold_w'(c_long_cyc);
    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(RAMP_STEP_CYC - 1);
    localparam logic [7:0]          c_fixed     = 8'(FIXED_BRIGHT);
    localparam logic [7:0]          c_bmin      = 8'(BRIGHT_MIN);
    localparam logic [1:0]          c_idx_cor   = 2'd3;

    typedef enum logic [1:0] {
        K_IDLE     = 2'd0,
        K_HOLD     = 2'd1,
        K_WAIT_REL = 2'd2
    } key_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RAMP = 1'b1
    } ramp_state_t;

    // ---------------- vsync synchroniser and rise detect ----------------
    logic r_vs_meta, r_vs_sync, r_vs_prev;
    logic w_vs_rise, w_commit_evt;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_meta <= I_vsync;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    assign w_vs_rise = r_vs_sync & ~r_vs_prev;

`ifdef VSYNC_TIMEOUT_EN
    localparam int c_to_w = $clog2(VS_TIMEOUT_CYC + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(VS_TIMEOUT_CYC);

    logic [c_to_w-1:0] r_to_cnt;
    logic              w_to_strobe;

    assign w_to_strobe = (r_to_cnt == c_to_last);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n)
            r_to_cnt <= '0;
        else if (w_vs_rise || w_to_strobe)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_commit_evt = w_vs_rise | w_to_strobe;
`else
    assign w_commit_evt = w_vs_rise;
`endif

    // ---------------- key tracker ----------------
    // Key index doubles as the gray code it stages: 0 RMS, 1 Max, 2 Ave, 3 Cor.
    logic [3:0]          w_key_n, r_key_n_prev, w_key_fall;
    logic [1:0]          w_fall_idx, r_trk;
    logic [c_hold_w-1:0] r_hold_cnt;
    key_state_t          r_k_state, w_k_next;
    logic                w_trk_load, w_trk_pressed, w_stage_gray, w_stage_sub;

    assign w_key_n    = {I_key_cor_n, I_key_ave_n, I_key_max_n, I_key_rms_n};
    assign w_key_fall = r_key_n_prev & ~w_key_n;

    always_comb begin
        w_fall_idx = 2'd3;
        if (w_key_fall[2]) w_fall_idx = 2'd2;
        if (w_key_fall[1]) w_fall_idx = 2'd1;
        if (w_key_fall[0]) w_fall_idx = 2'd0;
    end

    assign w_trk_pressed = ~w_key_n[r_trk];

    always_comb begin
        w_k_next     = r_k_state;
        w_trk_load   = 1'b0;
        w_stage_gray = 1'b0;
        w_stage_sub  = 1'b0;
        case (r_k_state)
            K_IDLE: begin
                if (|w_key_fall) begin
                    w_trk_load = 1'b1;
                    w_k_next   = K_HOLD;
                end
            end
            K_HOLD: begin
                if (r_trk == c_idx_cor && r_hold_cnt == c_long_v) begin
                    w_stage_sub = 1'b1;
                    w_k_next    = K_WAIT_REL;
                end else if (!w_trk_pressed) begin
                    w_stage_gray = 1'b1;
                    w_k_next     = K_IDLE;
                end
            end
            K_WAIT_REL: begin
                if (!w_trk_pressed)
                    w_k_next = K_IDLE;
            end
            default: w_k_next = K_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_k_state    <= K_IDLE;
            r_key_n_prev <= 4'hF;
            r_trk        <= 2'd0;
            r_hold_cnt   <= '0;
        end else begin
            r_k_state    <= w_k_next;
            r_key_n_prev <= w_key_n;
            if (w_trk_load) begin
                r_trk      <= w_fall_idx;
                r_hold_cnt <= '0;
            end else if (r_k_state == K_HOLD && r_hold_cnt != c_long_v) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    // ---------------- staging and frame commit ----------------
    logic [1:0] r_pend_gray, r_pend_sub, w_led_new;
    logic       r_pend_flag, w_do_commit;
    logic [7:0] r_target, w_target_new;

    always_comb begin
        w_led_new = 2'b01;
        if (!I_zonal_en)
            w_led_new = 2'b00;
        else if (I_auto_bright)
            w_led_new = 2'b10;
        else if (r_pend_sub[1])
            w_led_new = 2'b11;
    end

    assign w_target_new = (w_led_new == 2'b10) ? ((I_bright < c_bmin) ? c_bmin : I_bright)
                                               : c_fixed;
    assign w_do_commit  = w_commit_evt & (r_pend_flag | (w_led_new != O_led_mode));

    // Stage writes follow the commit so a same-cycle stage survives into the next frame.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_gray_mode  <= 2'b01;
            O_sub_mode   <= 2'b11;
            O_led_mode   <= 2'b00;
            O_cfg_update <= 1'b0;
            r_pend_gray  <= 2'b01;
            r_pend_sub   <= 2'b11;
            r_pend_flag  <= 1'b0;
            r_target     <= c_fixed;
        end else begin
            O_cfg_update <= 1'b0;
            if (w_do_commit) begin
                O_gray_mode  <= r_pend_gray;
                O_sub_mode   <= r_pend_sub;
                O_led_mode   <= w_led_new;
                O_cfg_update <= 1'b1;
                r_pend_flag  <= 1'b0;
            end
            if (w_stage_gray) begin
                r_pend_gray <= r_trk;
                r_pend_flag <= 1'b1;
            end
            if (w_stage_sub) begin
                r_pend_sub  <= r_pend_sub + 2'd1;
                r_pend_flag <= 1'b1;
            end
            if (w_commit_evt)
                r_target <= w_target_new;
        end
    end

    // ---------------- brightness ramp ----------------
    ramp_state_t         r_r_state, w_r_next;
    logic [c_step_w-1:0] r_step_cnt;
    logic                w_step_now;

    always_comb begin
        w_r_next   = r_r_state;
        w_step_now = 1'b0;
        case (r_r_state)
            R_IDLE: begin
                if (r_target != O_global_bright)
                    w_r_next = R_RAMP;
            end
            R_RAMP: begin
                if (r_target == O_global_bright)
                    w_r_next = R_IDLE;
                else if (r_step_cnt == c_step_last)
                    w_step_now = 1'b1;
            end
            default: w_r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_r_state       <= R_IDLE;
            r_step_cnt      <= '0;
            O_global_bright <= c_fixed;
        end else begin
            r_r_state <= w_r_next;
            if (r_r_state == R_IDLE || w_step_now)
                r_step_cnt <= '0;
            else
                r_step_cnt <= r_step_cnt + 1'b1;
            if (w_step_now) begin
                if (r_target > O_global_bright)
                    O_global_bright <= O_global_bright + 8'd1;
                else
                    O_global_bright <= O_global_bright - 8'd1;
            end
        end
    end

    assign O_ramp_busy = (r_r_state == R_RAMP);

endmodule
`default_nettype wire

// File: tb/tb_backlight_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_backlight_mode_ctrl
// Brief    : Directed bench with a frame-level behavioural model of
//            backlight_mode_ctrl, checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_backlight_mode_ctrl;

    localparam int c_step = 4;
    localparam int c_long = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0;
    logic [3:0] key_n = 4'hF;   // {cor, ave, max, rms}
    logic       zonal_en = 1'b0;
    logic       auto_br = 1'b0;
    logic [7:0] bright_in = 8'd0;
    logic [1:0] gray_mode, sub_mode, led_mode;
    logic [7:0] global_bright;
    logic       ramp_busy, cfg_update;

    always #5 clk = ~clk;

    backlight_mode_ctrl #(
        .CLK_FREQ_HZ(1000), .LONG_PRESS_MS(1000), .RAMP_STEP_CYC(c_step),
        .BRIGHT_MIN(16), .FIXED_BRIGHT(255), .VS_TIMEOUT_CYC(100)
    ) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_vsync(vsync),
        .I_key_rms_n(key_n[0]), .I_key_max_n(key_n[1]),
        .I_key_ave_n(key_n[2]), .I_key_cor_n(key_n[3]),
        .I_zonal_en(zonal_en), .I_auto_bright(auto_br), .I_bright(bright_in),
        .O_gray_mode(gray_mode), .O_sub_mode(sub_mode), .O_led_mode(led_mode),
        .O_global_bright(global_bright), .O_ramp_busy(ramp_busy),
        .O_cfg_update(cfg_update)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // Model: committed and pending configuration, plus a ramp described by
    // its start value, its target and the cycle the ramp begins.
    int m_gray, m_sub, m_led, m_pgray, m_psub;
    bit m_pflag, m_cfg;
    int m_bstart, m_btgt, m_ts;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int exp_bright(input int c);
        int d, mv;
        d = m_btgt - m_bstart;
        if (c < m_ts) return m_bstart;
        mv = (c - m_ts) / c_step;
        if (mv > iabs(d)) mv = iabs(d);
        return (d >= 0) ? m_bstart + mv : m_bstart - mv;
    endfunction

    function automatic int exp_busy(input int c);
        int ad;
        ad = iabs(m_btgt - m_bstart);
        return (ad != 0 && c >= m_ts && (c - m_ts) <= c_step * ad) ? 1 : 0;
    endfunction

    function automatic void check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endfunction

    task automatic model_reset();
        m_gray = 1; m_sub = 3; m_led = 0; m_pgray = 1; m_psub = 3;
        m_pflag = 0; m_cfg = 0;
        m_bstart = 255; m_btgt = 255; m_ts = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("gray_mode", int'(gray_mode), m_gray);
            check("sub_mode", int'(sub_mode), m_sub);
            check("led_mode", int'(led_mode), m_led);
            check("cfg_update", int'(cfg_update), int'(m_cfg));
            check("global_bright", int'(global_bright), exp_bright(cyc));
            check("ramp_busy", int'(ramp_busy), exp_busy(cyc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Press the keys in mask together, hold, release; stage per tracker rules.
    task automatic press(input logic [3:0] mask, input int hold);
        int trk;
        trk = mask[0] ? 0 : mask[1] ? 1 : mask[2] ? 2 : 3;
        key_n = ~mask;
        repeat (hold) step();
        key_n = 4'hF;
        repeat (4) step();
        if (trk < 3)             m_pgray = trk;
        else if (hold > c_long)  m_psub = (m_psub + 1) % 4;
        else                     m_pgray = 3;
        m_pflag = 1;
    endtask

    task automatic frame();
        int led_new, tgt;
        bit commit;
        vsync = 1'b1;
        led_new = !zonal_en ? 0 : auto_br ? 2 : (m_psub >= 2) ? 3 : 1;
        tgt = (led_new == 2) ? ((bright_in < 16) ? 16 : int'(bright_in)) : 255;
        commit = m_pflag || (led_new != m_led);
        repeat (3) step();
        m_bstart = exp_bright(cyc);
        m_btgt = tgt;
        m_ts = cyc + 1;
        if (commit) begin
            m_gray = m_pgray; m_sub = m_psub; m_led = led_new;
            m_cfg = 1; m_pflag = 0;
        end
        step();
        m_cfg = 0;
        vsync = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        model_reset();
        step();
        chk_en = 1'b1;
        step();
        rst_n = 1'b1;
        repeat (20) step();
        check("reset_gray", int'(gray_mode), 1);
        check("reset_sub", int'(sub_mode), 3);
        check("reset_bright", int'(global_bright), 255);

        frame();                               // nothing pending, led 00: no pulse

        zonal_en = 1'b1;
        press(4'b0100, 10);                    // Ave
        frame();
        check("ave_gray", int'(gray_mode), 2);
        check("ave_led", int'(led_mode), 3);

        press(4'b1000, 1200);                  // Cor long
        frame();
        check("cor_long_sub", int'(sub_mode), 0);
        check("cor_long_gray", int'(gray_mode), 2);
        check("cor_long_led", int'(led_mode), 1);
        press(4'b1000, 1200);
        frame();
        check("cor_long2_sub", int'(sub_mode), 1);
        press(4'b1000, 200);                   // Cor short
        frame();
        check("cor_short_gray", int'(gray_mode), 3);

        press(4'b0011, 10);                    // Max+RMS together
        frame();
        check("prio_gray", int'(gray_mode), 0);

        key_n = 4'b1110;                       // RMS hold, Max joins then lingers
        repeat (5) step();
        key_n = 4'b1100;
        repeat (5) step();
        key_n = 4'b1101;
        repeat (5) step();
        key_n = 4'b1111;
        repeat (5) step();
        m_pgray = 0; m_pflag = 1;
        frame();
        check("ignore_max_gray", int'(gray_mode), 0);

        press(4'b0100, 8);                     // last stage in a frame wins
        press(4'b0010, 8);
        frame();
        check("last_wins_gray", int'(gray_mode), 1);

        auto_br = 1'b1;
        bright_in = 8'd5;
        frame();                               // returns at ramp start + 4
        check("auto_led", int'(led_mode), 2);
        check("ramp_first_step", int'(global_bright), 254);
        repeat (952) step();
        check("ramp_end_bright", int'(global_bright), 16);
        check("ramp_end_busy", int'(ramp_busy), 1);
        step();
        check("ramp_idle_busy", int'(ramp_busy), 0);

        bright_in = 8'd200;
        frame();                               // target 200, no mode change
        repeat (50) step();
        rst_n = 1'b0;
        model_reset();
        step();
        check("rst_mid_bright", int'(global_bright), 255);
        check("rst_mid_busy", int'(ramp_busy), 0);
        rst_n = 1'b1;
        repeat (3) step();

        frame();                               // auto after reset: 255 -> 200
        repeat (230) step();
        check("final_bright", int'(global_bright), 200);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
